vec_cmd_queue: RTL
==================

Name: vec_cmd_queue

Overview:
- Sits directly downstream of the Wishbone-to-stream converter and upstream of the vector core.
- Takes the converter's instruction and load streams and enqueues each beat in arrival order into a DEPTH-entry FIFO. The FIFO then issues one command at a time to the core.
- Also carries the core's store-data return to the converter through a one-entry output register.

Parameters:
- DEPTH, 4, number of command entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset.
- instruction_recv_msg  in  32  instruction word from the converter.
- instruction_recv_val  in  1  instruction valid.
- instruction_recv_rdy  out  1  queue can accept.
- load_recv_msg  in  64  {[63:32] word index, [31:0] data}.
- load_recv_val  in  1  load beat valid; always paired with an instruction.
- load_recv_rdy  out  1  queue can accept.
- cmd_instr  out  32  head instruction.
- cmd_idx  out  32  head word index (0 if no load beat).
- cmd_data  out  32  head data (0 if no load beat).
- cmd_has_load  out  1  head entry carries a load beat.
- cmd_val  out  1  head valid.
- cmd_rdy  in  1  core accepts head.
- st_in_msg  in  32  store data from the core.
- st_in_val  in  1  store data valid.
- st_in_rdy  out  1  store register can accept.
- store_send_msg  out  32  store data to the converter.
- store_send_val  out  1  store data valid.
- store_send_rdy  in  1  converter takes store data.
- count  out  CNT_W  queue occupancy.
- proto_err  out  1  sticky: load beat arrived without an instruction.

Behaviour:
- Clock and reset: reset wb_rst_i, asynchronous, active-high; clock wb_clk_i.
- Reset values:
  - Pointers, count and proto_err = 0.
  - cmd_val = 0 and store_send_val = 0.
  - cmd_* data outputs = 0.
- Ready signals:
  - instruction_recv_rdy = load_recv_rdy = !full, where full means count == DEPTH.
  - Neither ready depends on any valid, because the converter acks on ready alone.
- Enqueue, on a cycle with ready high:
  - instruction_recv_val && load_recv_val: write one paired entry {has_load=1, instr, idx, data}.
  - instruction_recv_val && !load_recv_val: write a plain entry {has_load=0, instr, idx=0, data=0}.
  - load_recv_val && !instruction_recv_val: nothing is written; set proto_err (sticky until reset).
- Dequeue: when cmd_val && cmd_rdy, advance the read pointer.
- Head outputs:
  - cmd_val = (count != 0).
  - Head outputs are driven from the read-pointer entry.
  - Outputs hold stable while cmd_val && !cmd_rdy.
- Latency: an entry is visible on cmd_* on the cycle after it is enqueued.
- Simultaneous enqueue and dequeue:
  - Count is unchanged and both pointers advance.
  - When full, ready is low, so there is no enqueue that cycle even if a dequeue happens.
- Pointers: log2(DEPTH)-bit pointers wrap modulo DEPTH. Count tracks occupancy, range 0..DEPTH.
- Store register:
  - One entry; store_send_val = st_full.
  - st_in_rdy = !st_full || store_send_rdy.
  - On st_in_val && st_in_rdy, load st_in_msg and set st_full.
  - On a store_send_rdy handshake with no new input, clear st_full.
  - store_send_msg holds its value while valid and not taken.
- Reset mid-operation: all queued commands and any pending store data are discarded. No partial entries remain.

Optional Feature:
- Macro: VEC_CMDQ_BYPASS_EN.
- Defined: when count == 0, cmd_rdy is high and an enqueue is occurring, the incoming beat is presented combinationally on cmd_* with cmd_val = 1. It is consumed that same cycle and not written; count stays 0.
  - With count == 0 and cmd_rdy low, the beat is enqueued normally.
- Not defined: minimum latency is 1 cycle and there are no combinational paths from the inputs to cmd_*.

Decomposition:
- Package vec_cmd_pkg holds:
  - OP_LOAD = 5'b00000 and OP_STORE = 5'b00001 (instruction bits [31:27]).
  - Packed struct cmd_entry_t {has_load, instr[31:0], idx[31:0], data[31:0]}.
  - Field-width constants.
- Sub-module: sync_fifo, parameterised by width and DEPTH, holding storage, pointers and count. The top level handles pairing, proto_err, the bypass and the store register.

Test Plan:
- Plain instruction: send instr 0x12345678 alone with cmd_rdy=1 → next cycle cmd_val=1, cmd_instr=0x12345678, cmd_has_load=0, cmd_idx=0; count returns to 0 after the dequeue.
- Paired beat: instr 0x00000000 with load_msg {0x00000003, 0xDEADBEEF} → a single entry with has_load=1, idx=3, data=0xDEADBEEF.
- Fill and drain, DEPTH=4:
  - Push 4 entries with cmd_rdy=0 → both rdy go low and count=4; a 5th push is ignored.
  - Raise cmd_rdy → outputs come out in FIFO order, 4 beats, then cmd_val=0.
- Wrap with concurrency: push and pop every cycle for 10 cycles → count stays constant and the data sequence is preserved across pointer wrap.
- Store path:
  - st_in 0xCAFEF00D while store_send_rdy=0 → store_send_val=1 and st_in_rdy=0; a second store is blocked.
  - Raise store_send_rdy → a transfer occurs and the next store is accepted the same cycle.
- Error and reset:
  - load_recv_val alone → proto_err=1 and count unchanged.
  - Assert wb_rst_i with 2 entries queued → count=0, cmd_val=0, proto_err=0 immediately.

Source files
------------

// File: rtl/vec_cmd_queue_pkg.sv
// vec_cmd_pkg: shared opcodes, command entry layout and entry builder for vec_cmd_queue.
// Optional build macro for the queue: VEC_CMDQ_BYPASS_EN.
package vec_cmd_pkg;
    localparam int INSTR_W = 32;
    localparam int IDX_W   = 32;
    localparam int DATA_W  = 32;
    localparam int LOAD_W  = IDX_W + DATA_W;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b00001;
    typedef struct packed {
        logic               has_load;
        logic [INSTR_W-1:0] instr;
        logic [IDX_W-1:0]   idx;
        logic [DATA_W-1:0]  data;
    } cmd_entry_t;
    localparam int ENTRY_W = $bits(cmd_entry_t);
    // A plain instruction carries zero index/data so the head never shows stale load fields.
    function automatic cmd_entry_t make_entry(input logic [INSTR_W-1:0] instr, input logic has_load,
                                              input logic [LOAD_W-1:0] load_msg);
        make_entry.has_load = has_load;
        make_entry.instr    = instr;
        make_entry.idx      = has_load ? load_msg[LOAD_W-1:DATA_W] : '0;
        make_entry.data     = has_load ? load_msg[DATA_W-1:0] : '0;
    endfunction
endpackage

// File: rtl/vec_cmd_queue_if.sv
// vec_cmd_queue_if: converter-side streams, core command port and store-return path.
interface vec_cmd_queue_if;
    import vec_cmd_pkg::*;
    logic [INSTR_W-1:0] instruction_recv_msg;
    logic               instruction_recv_val;
    logic               instruction_recv_rdy;
    logic [LOAD_W-1:0]  load_recv_msg;
    logic               load_recv_val;
    logic               load_recv_rdy;
    logic [INSTR_W-1:0] cmd_instr;
    logic [IDX_W-1:0]   cmd_idx;
    logic [DATA_W-1:0]  cmd_data;
    logic               cmd_has_load;
    logic               cmd_val;
    logic               cmd_rdy;
    logic [DATA_W-1:0]  st_in_msg;
    logic               st_in_val;
    logic               st_in_rdy;
    logic [DATA_W-1:0]  store_send_msg;
    logic               store_send_val;
    logic               store_send_rdy;
    modport slave (
        input  instruction_recv_msg, instruction_recv_val, load_recv_msg, load_recv_val,
               cmd_rdy, st_in_msg, st_in_val, store_send_rdy,
        output instruction_recv_rdy, load_recv_rdy, cmd_instr, cmd_idx, cmd_data,
               cmd_has_load, cmd_val, st_in_rdy, store_send_msg, store_send_val
    );
    modport master (
        output instruction_recv_msg, instruction_recv_val, load_recv_msg, load_recv_val,
               cmd_rdy, st_in_msg, st_in_val, store_send_rdy,
        input  instruction_recv_rdy, load_recv_rdy, cmd_instr, cmd_idx, cmd_data,
               cmd_has_load, cmd_val, st_in_rdy, store_send_msg, store_send_val
    );
endinterface

// File: rtl/vec_cmd_queue_sync_fifo.sv
// sync_fifo: DEPTH-entry FIFO with wrapping pointers and an occupancy count.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr, rd;
    assign full    = count_q == CNT_W'(DEPTH);
    assign empty   = count_q == '0;
    assign wr      = wr_en && !full;
    assign rd      = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr) - CNT_W'(rd);
        if (wr) mem_d[wr_ptr_q] = wr_data;
    end
    // Storage is cleared on reset so the head reads zero before anything is written.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/vec_cmd_queue.sv
// vec_cmd_queue: pairs instruction/load beats into a command FIFO for the vector core, plus a store-return register.
// Build with VEC_CMDQ_BYPASS_EN to pass a beat straight through when the queue is empty and the core is ready.
module vec_cmd_queue
    import vec_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    vec_cmd_queue_if.slave   bus,
    output logic [CNT_W-1:0] count,
    output logic             proto_err
);
    cmd_entry_t        in_entry, head, out;
    logic              full, empty, enq, bypass;
    logic              proto_err_q, proto_err_d;
    logic              st_full_q, st_full_d;
    logic [DATA_W-1:0] st_msg_q, st_msg_d;
    logic              st_take;
    assign bus.instruction_recv_rdy = !full;
    assign bus.load_recv_rdy        = !full;
    assign enq      = bus.instruction_recv_val && !full;
    assign in_entry = make_entry(bus.instruction_recv_msg, bus.load_recv_val, bus.load_recv_msg);
`ifdef VEC_CMDQ_BYPASS_EN
    assign bypass      = empty && bus.cmd_rdy && enq;
    assign out         = bypass ? in_entry : head;
    assign bus.cmd_val = !empty || bypass;
`else
    assign bypass      = 1'b0;
    assign out         = head;
    assign bus.cmd_val = !empty;
`endif
    sync_fifo #(.W(ENTRY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wr_en    (enq && !bypass),
        .wr_data  (in_entry),
        .rd_en    (bus.cmd_rdy),
        .rd_data  (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );
    assign bus.cmd_instr    = out.instr;
    assign bus.cmd_idx      = out.idx;
    assign bus.cmd_data     = out.data;
    assign bus.cmd_has_load = out.has_load;
    assign proto_err          = proto_err_q;
    assign bus.st_in_rdy      = !st_full_q || bus.store_send_rdy;
    assign bus.store_send_val = st_full_q;
    assign bus.store_send_msg = st_msg_q;
    assign st_take            = bus.st_in_val && bus.st_in_rdy;
    // A new store refills the register in the same cycle the old one is taken.
    always_comb begin
        proto_err_d = proto_err_q || (bus.load_recv_val && !bus.instruction_recv_val && !full);
        st_full_d   = st_take ? 1'b1 : (bus.store_send_rdy ? 1'b0 : st_full_q);
        st_msg_d    = st_take ? bus.st_in_msg : st_msg_q;
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            proto_err_q <= 1'b0;
            st_full_q   <= 1'b0;
            st_msg_q    <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            st_full_q   <= st_full_d;
            st_msg_q    <= st_msg_d;
        end
    end
endmodule
